// File: rtl/mac_beams_tdm.sv
// mac_beams_tdm: time-multiplexed complex multiply-accumulate beamformer.
// An RE vector arrives as ANT/LANES beats of LANES antennas each. On every beat,
// each beam multiplies its weight slice with the antenna slice. The products are
// registered, then summed across lanes into a per-beam accumulator. After the last
// beat the sum is rounded, shifted and reduced to OW bits in the output register.
// Optional feature macro: MAC_BEAMS_TDM_SAT_EN. When it is defined, results saturate
// to OW bits and set a sticky o_ovf. When it is undefined, results wrap to OW bits
// and o_ovf is tied low.
module mac_beams_tdm #(
    parameter int BEAM  = 16,
    parameter int ANT   = 32,
    parameter int LANES = 8,
    parameter int IW    = 32,
    parameter int OW    = 40,
    parameter int SHIFT = 0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_tvalid,
    output logic                       o_ready,
    input  logic                       i_sop,
    input  logic                       i_eop,
    input  logic [LANES*IW-1:0]        i_ants_data,
    input  logic [BEAM*LANES*IW-1:0]   i_code_word,
    input  logic [63:0]                i_info_0,
    output logic                       o_tvalid,
    input  logic                       i_tready,
    output logic [BEAM*OW-1:0]         o_data_i,
    output logic [BEAM*OW-1:0]         o_data_q,
    output logic                       o_sop,
    output logic                       o_eop,
    output logic [63:0]                o_info_0,
    output logic                       o_ovf
);
    localparam int NB = ANT / LANES;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int HW = IW / 2;
    localparam int PW = IW + 1;
    localparam int AW = IW + 1 + $clog2(ANT);
    // One extra bit so that adding the rounding constant cannot overflow
    localparam int RW = AW + 1;
    localparam int XW = (OW > RW) ? OW : RW;
    localparam logic signed [RW-1:0] RND = RW'((2 ** SHIFT) / 2);
`ifdef MAC_BEAMS_TDM_SAT_EN
    localparam logic signed [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};
`endif

    function automatic logic signed [PW-1:0] sx(input logic [HW-1:0] v);
        return PW'(signed'(v));
    endfunction

    logic [CW-1:0]          beat;
    logic                   accept, first, last, in_flight;
    logic signed [PW-1:0]   prod_re [BEAM][LANES];
    logic signed [PW-1:0]   prod_im [BEAM][LANES];
    logic signed [PW-1:0]   p_re    [BEAM][LANES];
    logic signed [PW-1:0]   p_im    [BEAM][LANES];
    logic                   p_vld, p_first, p_last, p_sop, p_eop;
    logic [63:0]            p_info;
    logic                   v_sop, v_eop;
    logic [63:0]            v_info;
    logic signed [AW-1:0]   sum_re [BEAM];
    logic signed [AW-1:0]   sum_im [BEAM];
    logic signed [AW-1:0]   acc_re [BEAM];
    logic signed [AW-1:0]   acc_im [BEAM];
    logic                   a_done, a_sop, a_eop;
    logic [63:0]            a_info;
    logic signed [RW-1:0]   rnd_re [BEAM];
    logic signed [RW-1:0]   rnd_im [BEAM];
    logic signed [OW-1:0]   ext_re [BEAM];
    logic signed [OW-1:0]   ext_im [BEAM];
    logic signed [OW-1:0]   res_re [BEAM];
    logic signed [OW-1:0]   res_im [BEAM];
`ifdef MAC_BEAMS_TDM_SAT_EN
    logic                   sat_hit;
`endif

    assign first     = (beat == '0);
    assign last      = (beat == CW'(NB - 1));
    assign accept    = i_tvalid && o_ready;
    // A finished vector still in the pipe, or a stalled result, must not be overrun
    assign in_flight = (p_vld && p_last) || a_done;
    assign o_ready   = !last || !(in_flight || (o_tvalid && !i_tready));

    // Complex products of every lane against every beam's weight
    always_comb begin
        for (int bm = 0; bm < BEAM; bm++) begin
            for (int ln = 0; ln < LANES; ln++) begin
                prod_re[bm][ln] = sx(i_ants_data[ln*IW +: HW]) * sx(i_code_word[(bm*LANES+ln)*IW +: HW])
                                - sx(i_ants_data[ln*IW+HW +: HW]) * sx(i_code_word[(bm*LANES+ln)*IW+HW +: HW]);
                prod_im[bm][ln] = sx(i_ants_data[ln*IW +: HW]) * sx(i_code_word[(bm*LANES+ln)*IW+HW +: HW])
                                + sx(i_ants_data[ln*IW+HW +: HW]) * sx(i_code_word[(bm*LANES+ln)*IW +: HW]);
            end
        end
    end

    // Beat counter, product register and header capture on each accepted beat
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            beat    <= '0;
            p_vld   <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_sop   <= 1'b0;
            p_eop   <= 1'b0;
            p_info  <= '0;
            v_sop   <= 1'b0;
            v_eop   <= 1'b0;
            v_info  <= '0;
            for (int bm = 0; bm < BEAM; bm++) begin
                for (int ln = 0; ln < LANES; ln++) begin
                    p_re[bm][ln] <= '0;
                    p_im[bm][ln] <= '0;
                end
            end
        end else begin
            p_vld <= accept;
            if (accept) begin
                beat    <= last ? '0 : beat + CW'(1);
                p_first <= first;
                p_last  <= last;
                p_sop   <= first ? i_sop    : v_sop;
                p_eop   <= first ? i_eop    : v_eop;
                p_info  <= first ? i_info_0 : v_info;
                if (first) begin
                    v_sop  <= i_sop;
                    v_eop  <= i_eop;
                    v_info <= i_info_0;
                end
                for (int bm = 0; bm < BEAM; bm++) begin
                    for (int ln = 0; ln < LANES; ln++) begin
                        p_re[bm][ln] <= prod_re[bm][ln];
                        p_im[bm][ln] <= prod_im[bm][ln];
                    end
                end
            end
        end
    end

    // Lane reduction of the registered products
    always_comb begin
        for (int bm = 0; bm < BEAM; bm++) begin
            sum_re[bm] = '0;
            sum_im[bm] = '0;
            for (int ln = 0; ln < LANES; ln++) begin
                sum_re[bm] = sum_re[bm] + AW'(p_re[bm][ln]);
                sum_im[bm] = sum_im[bm] + AW'(p_im[bm][ln]);
            end
        end
    end

    // Accumulator: beat 0 loads, later beats add; header follows the last beat
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_done <= 1'b0;
            a_sop  <= 1'b0;
            a_eop  <= 1'b0;
            a_info <= '0;
            for (int bm = 0; bm < BEAM; bm++) begin
                acc_re[bm] <= '0;
                acc_im[bm] <= '0;
            end
        end else begin
            a_done <= p_vld && p_last;
            if (p_vld) begin
                for (int bm = 0; bm < BEAM; bm++) begin
                    acc_re[bm] <= p_first ? sum_re[bm] : acc_re[bm] + sum_re[bm];
                    acc_im[bm] <= p_first ? sum_im[bm] : acc_im[bm] + sum_im[bm];
                end
                if (p_last) begin
                    a_sop  <= p_sop;
                    a_eop  <= p_eop;
                    a_info <= p_info;
                end
            end
        end
    end

    // Round, shift and reduce each beam sum to OW bits
    always_comb begin
`ifdef MAC_BEAMS_TDM_SAT_EN
        sat_hit = 1'b0;
`endif
        for (int bm = 0; bm < BEAM; bm++) begin
            rnd_re[bm] = (RW'(acc_re[bm]) + RND) >>> SHIFT;
            rnd_im[bm] = (RW'(acc_im[bm]) + RND) >>> SHIFT;
            ext_re[bm] = OW'(rnd_re[bm]);
            ext_im[bm] = OW'(rnd_im[bm]);
`ifdef MAC_BEAMS_TDM_SAT_EN
            res_re[bm] = (XW'(ext_re[bm]) == XW'(rnd_re[bm])) ? ext_re[bm]
                       : (rnd_re[bm][RW-1] ? SAT_MIN : SAT_MAX);
            res_im[bm] = (XW'(ext_im[bm]) == XW'(rnd_im[bm])) ? ext_im[bm]
                       : (rnd_im[bm][RW-1] ? SAT_MIN : SAT_MAX);
            sat_hit = sat_hit || (XW'(ext_re[bm]) != XW'(rnd_re[bm]))
                              || (XW'(ext_im[bm]) != XW'(rnd_im[bm]));
`else
            res_re[bm] = ext_re[bm];
            res_im[bm] = ext_im[bm];
`endif
        end
    end

    // Output register: load a finished vector, hold while stalled, clear once consumed
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_tvalid <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_info_0 <= '0;
            o_data_i <= '0;
            o_data_q <= '0;
        end else if (a_done) begin
            o_tvalid <= 1'b1;
            o_sop    <= a_sop;
            o_eop    <= a_eop;
            o_info_0 <= a_info;
            for (int bm = 0; bm < BEAM; bm++) begin
                o_data_i[bm*OW +: OW] <= res_re[bm];
                o_data_q[bm*OW +: OW] <= res_im[bm];
            end
        end else if (o_tvalid && i_tready) begin
            o_tvalid <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_info_0 <= '0;
            o_data_i <= '0;
            o_data_q <= '0;
        end
    end

`ifdef MAC_BEAMS_TDM_SAT_EN
    // Sticky overflow, set together with the saturated result
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ovf <= 1'b0;
        end else if (a_done && sat_hit) begin
            o_ovf <= 1'b1;
        end
    end
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_beams_tdm.sv
// tb_mac_beams_tdm: randomized and directed scoreboard bench for mac_beams_tdm.
`timescale 1ns/1ps
module tb_mac_beams_tdm;
    localparam int BEAM  = 2;
    localparam int ANT   = 4;
    localparam int LANES = 2;
    localparam int IW    = 32;
    localparam int OW    = 24;
    localparam int SHIFT = 0;
    localparam int NB    = ANT / LANES;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     tvalid;
    logic                     o_ready;
    logic                     sop_in, eop_in;
    logic [LANES*IW-1:0]      ants;
    logic [BEAM*LANES*IW-1:0] code;
    logic [63:0]              info_in;
    logic                     o_tvalid;
    logic                     tready;
    logic [BEAM*OW-1:0]       o_data_i, o_data_q;
    logic                     o_sop, o_eop;
    logic [63:0]              o_info_0;
    logic                     o_ovf;

    mac_beams_tdm #(.BEAM(BEAM), .ANT(ANT), .LANES(LANES), .IW(IW), .OW(OW), .SHIFT(SHIFT)) dut (
        .i_clk(clk), .i_reset(rst), .i_tvalid(tvalid), .o_ready(o_ready),
        .i_sop(sop_in), .i_eop(eop_in), .i_ants_data(ants), .i_code_word(code),
        .i_info_0(info_in), .o_tvalid(o_tvalid), .i_tready(tready),
        .o_data_i(o_data_i), .o_data_q(o_data_q), .o_sop(o_sop), .o_eop(o_eop),
        .o_info_0(o_info_0), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BEAM*OW-1:0] di;
        logic [BEAM*OW-1:0] dq;
        logic               sop;
        logic               eop;
        logic [63:0]        info;
        logic               ovf;
        time                t_acc;
    } exp_t;

    exp_t sb[$];
    int   ant_i [ANT];
    int   ant_q [ANT];
    int   w_i   [BEAM][ANT];
    int   w_q   [BEAM][ANT];
    int   checks = 0;
    int   failures = 0;
    int   rdy_mode = 0;
    logic model_ovf = 1'b0;
    bit   presenting = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: round/shift then saturate or wrap, on plain 64-bit integers
    function automatic logic [OW-1:0] reduce(input longint v, output logic sat);
        longint r, hi, lo;
        r   = (v + ((64'sd1 <<< SHIFT) >>> 1)) >>> SHIFT;
        hi  = (64'sd1 <<< (OW - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
`ifdef MAC_BEAMS_TDM_SAT_EN
        if (r > hi) begin sat = 1'b1; r = hi; end
        else if (r < lo) begin sat = 1'b1; r = lo; end
`endif
        return r[OW-1:0];
    endfunction

    task automatic push_expected(input logic sp, input logic ep, input logic [63:0] inf, input time t);
        exp_t   e;
        longint re, im;
        logic   s_re, s_im;
        for (int bm = 0; bm < BEAM; bm++) begin
            re = 0;
            im = 0;
            for (int k = 0; k < ANT; k++) begin
                re += longint'(ant_i[k]) * longint'(w_i[bm][k]) - longint'(ant_q[k]) * longint'(w_q[bm][k]);
                im += longint'(ant_i[k]) * longint'(w_q[bm][k]) + longint'(ant_q[k]) * longint'(w_i[bm][k]);
            end
            e.di[bm*OW +: OW] = reduce(re, s_re);
            e.dq[bm*OW +: OW] = reduce(im, s_im);
            model_ovf = model_ovf | s_re | s_im;
        end
        e.sop = sp;
        e.eop = ep;
        e.info = inf;
        e.ovf = model_ovf;
        e.t_acc = t;
        sb.push_back(e);
    endtask

    task automatic fill(input int ai, input int aq, input int wi, input int wq);
        for (int k = 0; k < ANT; k++) begin
            ant_i[k] = ai;
            ant_q[k] = aq;
            for (int bm = 0; bm < BEAM; bm++) begin
                w_i[bm][k] = wi;
                w_q[bm][k] = wq;
            end
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < ANT; k++) begin
            ant_i[k] = int'($urandom_range(0, 65535)) - 32768;
            ant_q[k] = int'($urandom_range(0, 65535)) - 32768;
            for (int bm = 0; bm < BEAM; bm++) begin
                w_i[bm][k] = int'($urandom_range(0, 65535)) - 32768;
                w_q[bm][k] = int'($urandom_range(0, 65535)) - 32768;
            end
        end
    endtask

    task automatic load_beat(input int b);
        int k;
        for (int l = 0; l < LANES; l++) begin
            k = b * LANES + l;
            ants[l*IW +: IW] = {16'(ant_q[k]), 16'(ant_i[k])};
            for (int bm = 0; bm < BEAM; bm++)
                code[(bm*LANES+l)*IW +: IW] = {16'(w_q[bm][k]), 16'(w_i[bm][k])};
        end
    endtask

    // Non-first beats carry inverted markers and altered info, which must be ignored
    task automatic send_vector(input logic sp, input logic ep, input logic [63:0] inf, input bit gaps);
        int n;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            if (gaps) while ($urandom_range(0, 3) == 0) @(negedge clk);
            tvalid  = 1'b1;
            sop_in  = (b == 0) ? sp : ~sp;
            eop_in  = (b == 0) ? ep : ~ep;
            info_in = (b == 0) ? inf : (inf ^ 64'hFF);
            load_beat(b);
            #1;
            n = 0;
            while (!o_ready && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (!o_ready) begin
                checks++;
                failures++;
                $display("FAIL ready_timeout got=0 exp=1");
                tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            if (b == NB - 1) push_expected(sp, ep, inf, $time);
            #1 tvalid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || o_tvalid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || o_tvalid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Downstream ready pattern
    always @(negedge clk) begin
        case (rdy_mode)
            0:       tready = 1'b1;
            1:       tready = ($urandom_range(0, 3) != 0);
            default: tready = 1'b0;
        endcase
    end

    // Monitor: compares every presented result against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (o_tvalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid got=1 exp=0");
                end else begin
                    e = sb[0];
                    if (!presenting) chk("latency", $time - e.t_acc, 64'd27);
                    chk("data_i", o_data_i, e.di);
                    chk("data_q", o_data_q, e.dq);
                    chk("sop", o_sop, e.sop);
                    chk("eop", o_eop, e.eop);
                    chk("info", o_info_0, e.info);
                    chk("ovf", o_ovf, e.ovf);
                    presenting = 1'b1;
                    if (tready) begin
                        void'(sb.pop_front());
                        presenting = 1'b0;
                    end
                end
            end else if (presenting) begin
                checks++;
                failures++;
                $display("FAIL dropped_valid got=0 exp=1");
                presenting = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        tvalid = 1'b0;
        sop_in = 1'b0;
        eop_in = 1'b0;
        info_in = '0;
        ants = '0;
        code = '0;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_tvalid", o_tvalid, 0);
        chk("reset_data_i", o_data_i, 0);
        chk("reset_data_q", o_data_q, 0);
        chk("reset_sop", o_sop, 0);
        chk("reset_eop", o_eop, 0);
        chk("reset_info", o_info_0, 0);
        chk("reset_ovf", o_ovf, 0);
        chk("reset_ready", o_ready, 1);

        // Unit products, j*j, j*(-j), then full-scale negative operands
        fill(1, 0, 1, 0);
        send_vector(1'b1, 1'b1, 64'h1, 1'b0);
        fill(0, 1, 0, 1);
        send_vector(1'b0, 1'b0, 64'h2, 1'b0);
        fill(0, 1, 0, -1);
        send_vector(1'b1, 1'b0, 64'h3, 1'b0);
        fill(-32768, -32768, -32768, -32768);
        send_vector(1'b0, 1'b1, 64'h4, 1'b0);
        wait_drain();

        // Downstream stall across two back-to-back vectors
        rdy_mode = 2;
        fill(1, 0, 1, 0);
        send_vector(1'b1, 1'b0, 64'h10, 1'b0);
        fill(2, 0, 1, 0);
        fork
            send_vector(1'b0, 1'b1, 64'h11, 1'b0);
            begin
                repeat (8) @(negedge clk);
                #1;
                chk("stall_ready_blocked", o_ready, 0);
                chk("stall_result_held", o_tvalid, 1);
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Reset in the middle of a vector discards the partial sum
        fill(32767, 0, 1, 0);
        @(negedge clk);
        tvalid = 1'b1;
        sop_in = 1'b1;
        eop_in = 1'b0;
        info_in = 64'h77;
        load_beat(0);
        @(posedge clk);
        #1 tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ovf = 1'b0;
        #1;
        chk("midreset_tvalid", o_tvalid, 0);
        chk("midreset_ready", o_ready, 1);
        chk("midreset_ovf", o_ovf, 0);
        fill(1, 0, 1, 0);
        send_vector(1'b0, 1'b1, 64'h20, 1'b0);
        wait_drain();

        // Header sampled only from the first beat
        fill_rand();
        send_vector(1'b1, 1'b0, 64'hA5, 1'b0);
        wait_drain();

        // Randomized data, headers, input gaps and downstream backpressure
        rdy_mode = 1;
        for (int v = 0; v < 40; v++) begin
            fill_rand();
            send_vector(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        {$urandom, $urandom}, 1'b1);
        end
        rdy_mode = 0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
